// File: rtl/ssg_pkg.sv
// ssg_pkg: shared constants and helpers for the seven-segment scan controller.
//   - GUARD_SUBPHASE / LAST_SUBPHASE : subphase numbering of the PWM slot
//   - BLINK_DIV_Rn                   : divisors of CLK_FREQUENCY_HZ per blink rate
//   - blink_half_period()            : blink half-period in clocks for a rate select
//   - hex_to_seg()                   : 0-F to active-low {g,f,e,d,c,b,a} table
package ssg_pkg;

  // Subphase 0 of every digit slot keeps all anodes off so the previous
  // digit's pattern cannot ghost onto the next anode.
  localparam logic [3:0] GUARD_SUBPHASE = 4'd0;
  localparam logic [3:0] LAST_SUBPHASE  = 4'd15;

  // Blink half-period = CLK_FREQUENCY_HZ / divisor (rate 0 is 2*F, rate 1 is F).
  localparam int unsigned BLINK_DIV_R2 = 2;
  localparam int unsigned BLINK_DIV_R3 = 4;
  localparam int unsigned BLINK_DIV_R4 = 8;
  localparam int unsigned BLINK_DIV_R5 = 16;
  localparam int unsigned BLINK_DIV_R6 = 20;
  localparam int unsigned BLINK_DIV_R7 = 24;

  // Only ever called with constant arguments, so it folds to a constant.
  function automatic logic [31:0] blink_half_period(input logic [2:0]  sel,
                                                    input int unsigned clk_hz);
    int unsigned half;
    case (sel)
      3'd0:    half = clk_hz * 2;
      3'd1:    half = clk_hz;
      3'd2:    half = clk_hz / BLINK_DIV_R2;
      3'd3:    half = clk_hz / BLINK_DIV_R3;
      3'd4:    half = clk_hz / BLINK_DIV_R4;
      3'd5:    half = clk_hz / BLINK_DIV_R5;
      3'd6:    half = clk_hz / BLINK_DIV_R6;
      default: half = clk_hz / BLINK_DIV_R7;
    endcase
    // A zero half-period would never hit terminal count; clamp to 1.
    if (half == 0) half = 1;
    return half;
  endfunction

  function automatic logic [6:0] hex_to_seg(input logic [3:0] value);
    logic [6:0] seg;
    case (value)
      4'h0:    seg = 7'b1000000;
      4'h1:    seg = 7'b1111001;
      4'h2:    seg = 7'b0100100;
      4'h3:    seg = 7'b0110000;
      4'h4:    seg = 7'b0011001;
      4'h5:    seg = 7'b0010010;
      4'h6:    seg = 7'b0000010;
      4'h7:    seg = 7'b1111000;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0010000;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b0000011;
      4'hC:    seg = 7'b1000110;
      4'hD:    seg = 7'b0100001;
      4'hE:    seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/ssg_blink_gen.sv
// ssg_blink_gen: square-wave blink phase generator.
//   CLK         in  system clock, rising edge
//   RESET       in  synchronous active-high reset
//   BLINK_RATE  in  half-period select 0..7
//   BLINK_PHASE out toggles each time the counter reaches its terminal count
module ssg_blink_gen
  import ssg_pkg::*;
#(
  parameter int unsigned CLK_FREQUENCY_HZ = 50000000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [2:0] BLINK_RATE,
  output logic       BLINK_PHASE
);

  localparam logic [31:0] HALF_0 = blink_half_period(3'd0, CLK_FREQUENCY_HZ);
  localparam logic [31:0] HALF_1 = blink_half_period(3'd1, CLK_FREQUENCY_HZ);
  localparam logic [31:0] HALF_2 = blink_half_period(3'd2, CLK_FREQUENCY_HZ);
  localparam logic [31:0] HALF_3 = blink_half_period(3'd3, CLK_FREQUENCY_HZ);
  localparam logic [31:0] HALF_4 = blink_half_period(3'd4, CLK_FREQUENCY_HZ);
  localparam logic [31:0] HALF_5 = blink_half_period(3'd5, CLK_FREQUENCY_HZ);
  localparam logic [31:0] HALF_6 = blink_half_period(3'd6, CLK_FREQUENCY_HZ);
  localparam logic [31:0] HALF_7 = blink_half_period(3'd7, CLK_FREQUENCY_HZ);

  logic [31:0] cnt_q, cnt_d;
  logic [2:0]  rate_q, rate_d;
  logic        phase_q, phase_d;
  logic [31:0] half;

  always_comb begin
    case (rate_q)
      3'd0:    half = HALF_0;
      3'd1:    half = HALF_1;
      3'd2:    half = HALF_2;
      3'd3:    half = HALF_3;
      3'd4:    half = HALF_4;
      3'd5:    half = HALF_5;
      3'd6:    half = HALF_6;
      default: half = HALF_7;
    endcase

    cnt_d   = cnt_q + 32'd1;
    rate_d  = rate_q;
    phase_d = phase_q;
    // A rate change restarts the period from 0 and suppresses the toggle
    // that a stale count could otherwise produce against the new limit.
    if (BLINK_RATE != rate_q) begin
      cnt_d  = '0;
      rate_d = BLINK_RATE;
    end else if (cnt_q >= half - 32'd1) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt_q   <= '0;
      rate_q  <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      rate_q  <= rate_d;
      phase_q <= phase_d;
    end
  end

  assign BLINK_PHASE = phase_q;

endmodule

// File: rtl/ssg_mux_ctrl.sv
// ssg_mux_ctrl: multiplexed seven-segment display scanner with PWM brightness.
//   CLK, RESET        clock and synchronous active-high reset
//   DIN               hex value, nibble i shown on digit i
//   SEG_DATA          raw active-low {g..a,dp} byte per digit (dp used in both modes)
//   REFRESH_RATE_DIV  clocks per PWM subphase (0/1 = one clock)
//   BLANK, BLINK      per-digit force-off / blink enable
//   AUTOBLANK         hide leading zero digits in hex mode
//   BLINK_RATE        blink period select, see ssg_blink_gen
//   USE_SEGMENT_DATA  1 = show SEG_DATA bytes, 0 = decode DIN
//   BRIGHTNESS        number of lit subphases per 16-subphase slot
//   AN, SEG           registered anode / segment drive
//   FRAME_DONE        one-cycle pulse as the scan returns to digit 0
// Each digit slot is 16 subphases; subphase 0 is a dark guard. All display
// inputs are sampled into shadow registers once per frame.
module ssg_mux_ctrl
  import ssg_pkg::*;
#(
  parameter int          NUM_DIGITS       = 8,
  parameter int unsigned CLK_FREQUENCY_HZ = 50000000,
  parameter bit          ANODE_ACTIVE_LOW = 1'b1,
  parameter bit          SEG_ACTIVE_LOW   = 1'b1
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic [4*NUM_DIGITS-1:0] DIN,
  input  logic [8*NUM_DIGITS-1:0] SEG_DATA,
  input  logic [23:0]             REFRESH_RATE_DIV,
  input  logic [NUM_DIGITS-1:0]   BLANK,
  input  logic                    AUTOBLANK,
  input  logic [NUM_DIGITS-1:0]   BLINK,
  input  logic [2:0]              BLINK_RATE,
  input  logic                    USE_SEGMENT_DATA,
  input  logic [3:0]              BRIGHTNESS,
  output logic [NUM_DIGITS-1:0]   AN,
  output logic [7:0]              SEG,
  output logic                    FRAME_DONE
);

  localparam int DIG_W = $clog2(NUM_DIGITS);
  localparam logic [DIG_W-1:0]      LAST_DIGIT = DIG_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_OFF     = ANODE_ACTIVE_LOW ? '1 : '0;
  localparam logic [7:0]            SEG_OFF    = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;

  // Scan counters
  logic [23:0]      pre_q, pre_d;
  logic [3:0]       sub_q, sub_d;
  logic [DIG_W-1:0] dig_q, dig_d;
  logic             frame_done_q, frame_done_d;
  logic             load_pend_q, load_pend_d;

  // Shadow copies of the display inputs
  logic [4*NUM_DIGITS-1:0] din_s_q, din_s_d;
  logic [8*NUM_DIGITS-1:0] seg_data_s_q, seg_data_s_d;
  logic [NUM_DIGITS-1:0]   blank_s_q, blank_s_d;
  logic [NUM_DIGITS-1:0]   blink_s_q, blink_s_d;
  logic                    autoblank_s_q, autoblank_s_d;
  logic                    use_seg_s_q, use_seg_s_d;
  logic [3:0]              bright_s_q, bright_s_d;

  // Registered outputs
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [7:0]            seg_q, seg_d;

  // Combinational helpers
  logic                  tick;
  logic                  wrap;
  logic                  capture;
  logic                  blink_phase;
  logic                  zero_run;
  logic [NUM_DIGITS-1:0] lead_zero;
  logic [3:0]            cur_nib;
  logic [7:0]            cur_byte;
  logic [7:0]            pattern;
  logic [NUM_DIGITS-1:0] onehot;
  logic                  lit;

  ssg_blink_gen #(
    .CLK_FREQUENCY_HZ(CLK_FREQUENCY_HZ)
  ) u_blink (
    .CLK        (CLK),
    .RESET      (RESET),
    .BLINK_RATE (BLINK_RATE),
    .BLINK_PHASE(blink_phase)
  );

  // Prescaler, subphase and digit counters
  always_comb begin
    // '>=' keeps the prescaler from running away if the divider shrinks mid-count.
    tick  = (REFRESH_RATE_DIV <= 24'd1) || (pre_q >= REFRESH_RATE_DIV - 24'd1);
    pre_d = tick ? '0 : pre_q + 24'd1;
    sub_d = sub_q;
    dig_d = dig_q;
    wrap  = 1'b0;
    if (tick) begin
      sub_d = sub_q + 4'd1;
      if (sub_q == LAST_SUBPHASE) begin
        if (dig_q == LAST_DIGIT) begin
          dig_d = '0;
          wrap  = 1'b1;
        end else begin
          dig_d = dig_q + DIG_W'(1);
        end
      end
    end
    frame_done_d = wrap;
  end

  // Shadow capture: once right after reset, then at every frame boundary
  always_comb begin
    capture       = load_pend_q || wrap;
    load_pend_d   = 1'b0;
    din_s_d       = capture ? DIN              : din_s_q;
    seg_data_s_d  = capture ? SEG_DATA         : seg_data_s_q;
    blank_s_d     = capture ? BLANK            : blank_s_q;
    blink_s_d     = capture ? BLINK            : blink_s_q;
    autoblank_s_d = capture ? AUTOBLANK        : autoblank_s_q;
    use_seg_s_d   = capture ? USE_SEGMENT_DATA : use_seg_s_q;
    bright_s_d    = capture ? BRIGHTNESS       : bright_s_q;
  end

  // Output decision for the digit currently being scanned
  always_comb begin
    // lead_zero[i]: nibbles i..top are all zero. Digit 0 always shows.
    lead_zero = '0;
    zero_run  = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run     = zero_run && (din_s_q[4*i +: 4] == 4'd0);
      lead_zero[i] = zero_run;
    end
    lead_zero[0] = 1'b0;

    cur_nib  = din_s_q[4*dig_q +: 4];
    cur_byte = seg_data_s_q[8*dig_q +: 8];
    pattern  = use_seg_s_q ? cur_byte : {hex_to_seg(cur_nib), cur_byte[0]};

    lit = (sub_q != GUARD_SUBPHASE) && (sub_q <= bright_s_q)
          && !blank_s_q[dig_q]
          && !(autoblank_s_q && !use_seg_s_q && lead_zero[dig_q])
          && !(blink_s_q[dig_q] && blink_phase);

    onehot        = '0;
    onehot[dig_q] = 1'b1;

    an_d  = AN_OFF;
    seg_d = SEG_OFF;
    if (lit) begin
      an_d  = ANODE_ACTIVE_LOW ? ~onehot : onehot;
      seg_d = SEG_ACTIVE_LOW ? pattern : ~pattern;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      pre_q         <= '0;
      sub_q         <= '0;
      dig_q         <= '0;
      frame_done_q  <= 1'b0;
      load_pend_q   <= 1'b1;
      din_s_q       <= '0;
      seg_data_s_q  <= '0;
      blank_s_q     <= '0;
      blink_s_q     <= '0;
      autoblank_s_q <= 1'b0;
      use_seg_s_q   <= 1'b0;
      bright_s_q    <= '0;
      an_q          <= AN_OFF;
      seg_q         <= SEG_OFF;
    end else begin
      pre_q         <= pre_d;
      sub_q         <= sub_d;
      dig_q         <= dig_d;
      frame_done_q  <= frame_done_d;
      load_pend_q   <= load_pend_d;
      din_s_q       <= din_s_d;
      seg_data_s_q  <= seg_data_s_d;
      blank_s_q     <= blank_s_d;
      blink_s_q     <= blink_s_d;
      autoblank_s_q <= autoblank_s_d;
      use_seg_s_q   <= use_seg_s_d;
      bright_s_q    <= bright_s_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
    end
  end

  assign AN         = an_q;
  assign SEG        = seg_q;
  assign FRAME_DONE = frame_done_q;

endmodule

// File: tb/tb_ssg_mux_ctrl.sv
// Bench for ssg_mux_ctrl (8 digits, 160 Hz clock parameter so blink windows are short).
module tb_ssg_mux_ctrl;

  localparam int          ND   = 8;
  localparam int unsigned F_HZ = 160;

  // Clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // DUT signals
  logic [4*ND-1:0] din;
  logic [8*ND-1:0] seg_data;
  logic [23:0]     div;
  logic [ND-1:0]   blank;
  logic            autoblank;
  logic [ND-1:0]   blink;
  logic [2:0]      blink_rate;
  logic            use_seg;
  logic [3:0]      bright;
  logic [ND-1:0]   an;
  logic [7:0]      seg;
  logic            frame_done;

  ssg_mux_ctrl #(
    .NUM_DIGITS      (ND),
    .CLK_FREQUENCY_HZ(F_HZ),
    .ANODE_ACTIVE_LOW(1'b1),
    .SEG_ACTIVE_LOW  (1'b1)
  ) dut (
    .CLK             (clk),
    .RESET           (rst),
    .DIN             (din),
    .SEG_DATA        (seg_data),
    .REFRESH_RATE_DIV(div),
    .BLANK           (blank),
    .AUTOBLANK       (autoblank),
    .BLINK           (blink),
    .BLINK_RATE      (blink_rate),
    .USE_SEGMENT_DATA(use_seg),
    .BRIGHTNESS      (bright),
    .AN              (an),
    .SEG             (seg),
    .FRAME_DONE      (frame_done)
  );

  // Scoreboard: per-digit {lit cycle count, SEG while lit}
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] exp_q[$];

  // Standard active-low g..a patterns
  logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic set_defaults();
    din        = '0;
    seg_data   = '1;
    div        = 24'd2;
    blank      = '0;
    blink      = '0;
    autoblank  = 1'b0;
    blink_rate = 3'd0;
    use_seg    = 1'b0;
    bright     = 4'd15;
  endtask

  // Model of one frame from the inputs that the next capture will take.
  task automatic push_frame_expect();
    int          eff_div;
    logic        zero_run;
    logic [ND-1:0] lz;
    logic        off;
    logic [7:0]  s;
    int          lit;
    eff_div  = (div <= 24'd1) ? 1 : int'(div);
    zero_run = 1'b1;
    for (int i = ND - 1; i >= 0; i--) begin
      zero_run = zero_run && (din[4*i +: 4] == 4'd0);
      lz[i]    = zero_run && (i > 0);
    end
    for (int k = 0; k < ND; k++) begin
      off = blank[k] || (autoblank && !use_seg && lz[k]);
      lit = off ? 0 : int'(bright) * eff_div;
      s   = use_seg ? seg_data[8*k +: 8] : {hex_tab[din[4*k +: 4]], seg_data[8*k]};
      if (lit == 0) s = 8'hFF;
      exp_q.push_back({8'(lit), s});
    end
  endtask

  task automatic wait_frame_done(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_done !== 1'b1 && n < 2000);
    if (frame_done !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s frame_done_timeout: waited %0d cycles, required a pulse", tag, n);
    end
  endtask

  // Observes one frame starting right after a FRAME_DONE sample and compares
  // each digit slot against the scoreboard. Optionally changes DIN mid-frame.
  task automatic check_frame(input string tag, input int change_at, input logic [4*ND-1:0] new_din);
    int            eff_div, slot, cyc, lit_cnt;
    logic [ND-1:0] onehot;
    logic [15:0]   exp;
    logic [7:0]    seen;
    logic          fd_exp;
    bit            bad_an, seg_var, bad_off, fd_bad;
    eff_div = (div <= 24'd1) ? 1 : int'(div);
    slot    = 16 * eff_div;
    cyc     = 0;
    fd_bad  = 0;
    for (int k = 0; k < ND; k++) begin
      onehot    = '0;
      onehot[k] = 1'b1;
      lit_cnt   = 0;
      seen      = 8'hFF;
      bad_an    = 0;
      seg_var   = 0;
      bad_off   = 0;
      for (int j = 0; j < slot; j++) begin
        @(negedge clk);
        cyc++;
        if (cyc == change_at) din = new_din;
        if (an === ~onehot) begin
          lit_cnt++;
          if (lit_cnt == 1) seen = seg;
          else if (seg !== seen) seg_var = 1;
        end else if (an !== '1) begin
          bad_an = 1;
        end else if (seg !== 8'hFF) begin
          bad_off = 1;
        end
        fd_exp = (cyc == slot * ND);
        if (frame_done !== fd_exp) fd_bad = 1;
      end
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL %s scoreboard_empty: digit %0d has no expected entry", tag, k);
      end else begin
        exp = exp_q.pop_front();
        n_checks++;
        if (lit_cnt != int'(exp[15:8])) begin
          n_fail++;
          $display("FAIL %s lit_count digit %0d: got %0d expected %0d", tag, k, lit_cnt, exp[15:8]);
        end
        n_checks++;
        if (seen !== exp[7:0]) begin
          n_fail++;
          $display("FAIL %s seg digit %0d: got %h expected %h", tag, k, seen, exp[7:0]);
        end
        n_checks++;
        if (bad_an || seg_var || bad_off) begin
          n_fail++;
          $display("FAIL %s slot_integrity digit %0d: bad_an=%0d seg_var=%0d seg_when_off=%0d expected all 0",
                   tag, k, bad_an, seg_var, bad_off);
        end
      end
    end
    n_checks++;
    if (fd_bad) begin
      n_fail++;
      $display("FAIL %s frame_done_timing: pulse not exactly at cycle %0d", tag, slot * ND);
    end
  endtask

  // Releases reset (caller is at a negedge) and checks the restart of the scan.
  task automatic release_check(input string tag, input logic [7:0] exp_first_seg);
    int         cnt, first_lit;
    logic [7:0] first_an, first_seg;
    cnt       = 0;
    first_lit = -1;
    first_an  = '1;
    first_seg = 8'hFF;
    rst       = 1'b0;
    do begin
      @(negedge clk);
      cnt++;
      if (first_lit < 0 && an !== '1) begin
        first_lit = cnt;
        first_an  = an;
        first_seg = seg;
      end
    end while (frame_done !== 1'b1 && cnt < 1000);
    n_checks++;
    if (first_lit != 3) begin
      n_fail++;
      $display("FAIL %s first_lit_cycle: got %0d expected 3", tag, first_lit);
    end
    n_checks++;
    if (first_an !== 8'hFE) begin
      n_fail++;
      $display("FAIL %s first_an: got %h expected fe", tag, first_an);
    end
    n_checks++;
    if (first_seg !== exp_first_seg) begin
      n_fail++;
      $display("FAIL %s first_seg: got %h expected %h", tag, first_seg, exp_first_seg);
    end
    n_checks++;
    if (cnt != 256 || frame_done !== 1'b1) begin
      n_fail++;
      $display("FAIL %s first_frame_done: got cycle %0d (fd=%b) expected 256", tag, cnt, frame_done);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    n_checks++;
    if (an !== 8'hFF) begin
      n_fail++;
      $display("FAIL %s an: got %h expected ff", tag, an);
    end
    n_checks++;
    if (seg !== 8'hFF) begin
      n_fail++;
      $display("FAIL %s seg: got %h expected ff", tag, seg);
    end
    n_checks++;
    if (frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL %s frame_done: got %b expected 0", tag, frame_done);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    set_defaults();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    release_check("startup", {hex_tab[0], 1'b1});
  endtask

  task automatic test_full_brightness();
    set_defaults();
    din      = $urandom;
    seg_data = {$urandom, $urandom};
    push_frame_expect();
    wait_frame_done("full");
    check_frame("full", -1, '0);
  endtask

  task automatic test_segment_mode();
    set_defaults();
    use_seg   = 1'b1;
    autoblank = 1'b1;
    din       = '0;
    seg_data  = {$urandom, $urandom};
    push_frame_expect();
    wait_frame_done("segmode");
    check_frame("segmode", -1, '0);
  endtask

  task automatic test_brightness_levels();
    logic [3:0] levels [3];
    levels = '{4'd0, 4'd1, 4'd7};
    for (int i = 0; i < 3; i++) begin
      set_defaults();
      din    = $urandom;
      bright = levels[i];
      push_frame_expect();
      wait_frame_done("bright");
      check_frame($sformatf("bright%0d", levels[i]), -1, '0);
    end
  endtask

  task automatic test_fast_refresh();
    logic [23:0] divs [2];
    divs = '{24'd0, 24'd1};
    for (int i = 0; i < 2; i++) begin
      set_defaults();
      din    = $urandom;
      div    = divs[i];
      bright = 4'($urandom_range(1, 15));
      push_frame_expect();
      wait_frame_done("fast");
      check_frame($sformatf("div%0d", divs[i]), -1, '0);
    end
  endtask

  task automatic test_autoblank();
    logic [31:0] vals [3];
    vals = '{32'h0000_00A0, 32'h0000_0000, 32'h0010_0000};
    for (int i = 0; i < 3; i++) begin
      set_defaults();
      autoblank = 1'b1;
      din       = vals[i];
      push_frame_expect();
      wait_frame_done("autoblank");
      check_frame($sformatf("autoblank_%h", vals[i]), -1, '0);
    end
  endtask

  task automatic test_blank();
    set_defaults();
    din   = $urandom;
    blank = 8'($urandom_range(1, 254));
    push_frame_expect();
    wait_frame_done("blank");
    check_frame("blank", -1, '0);
  endtask

  task automatic test_mid_frame_change();
    logic [31:0] new_val;
    set_defaults();
    din     = 32'h1234_5678;
    new_val = 32'h9ABC_DEF0;
    push_frame_expect();
    wait_frame_done("midframe");
    check_frame("mid_old", 100, new_val);
    push_frame_expect();
    check_frame("mid_new", -1, '0);
  endtask

  // Digit 0 blinks with a 40-cycle half-period (160/4). REFRESH_RATE_DIV=0 so
  // the scan position is the cycle count since reset release.
  task automatic test_blink();
    int   win_exp, win_obs, t, dig, sub;
    logic phase, lit;
    set_defaults();
    din        = $urandom;
    div        = 24'd0;
    blink      = 8'h01;
    blink_rate = 3'd3;
    rst        = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    // Expected digit-0 lit cycles per 40-cycle window of observation
    for (int w = 0; w < 16; w++) begin
      win_exp = 0;
      for (int c = 0; c < 40; c++) begin
        t     = 40 * w + c;          // state cycle shown at observation cycle t+1
        dig   = (t / 16) % ND;
        sub   = t % 16;
        phase = (t >= 1) ? 1'(((t - 1) / 40) % 2) : 1'b0;
        lit   = (t >= 1) && (dig == 0) && (sub != 0) && !phase;
        if (lit) win_exp++;
      end
      exp_q.push_back(16'(win_exp));
    end
    for (int w = 0; w < 16; w++) begin
      win_obs = 0;
      for (int c = 0; c < 40; c++) begin
        @(negedge clk);
        if (an[0] === 1'b0) win_obs++;
      end
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL blink scoreboard_empty: window %0d", w);
      end else if (16'(win_obs) !== exp_q[0]) begin
        n_fail++;
        $display("FAIL blink window %0d: got %0d lit cycles expected %0d", w, win_obs, exp_q[0]);
        void'(exp_q.pop_front());
      end else begin
        void'(exp_q.pop_front());
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int n;
    set_defaults();
    din = 32'h0000_0007;
    wait_frame_done("rst_mid");
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (an !== 8'hDF && n < 600);
    n_checks++;
    if (an !== 8'hDF) begin
      n_fail++;
      $display("FAIL rst_mid digit5_timeout: an=%h expected df", an);
    end
    rst = 1'b1;
    @(negedge clk);
    check_idle_outputs("rst_mid_next_edge");
    @(negedge clk);
    release_check("rst_mid_restart", {hex_tab[7], 1'b1});
  endtask

  // ---------------- main sequence ----------------
  initial begin
    set_defaults();
    rst = 1'b1;
    test_reset();
    test_full_brightness();
    test_segment_mode();
    test_brightness_levels();
    test_fast_refresh();
    test_autoblank();
    test_blank();
    test_mid_frame_change();
    test_blink();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
